// File: rtl/vga_posicionador_embarcacao.sv
// Placement controller for one vessel on the VGA board grid: button-driven anchor and
// orientation with clamping and auto-repeat, plus a valid/accept/reject commit handshake.
module vga_posicionador_embarcacao #(
    parameter int TAMANHO       = 3,
    parameter int MAX_CELULAS   = 8,
    parameter int COORD_W       = 4,
    parameter int GRID_W        = 10,
    parameter int GRID_H        = 10,
    parameter int INIT_X        = 4,
    parameter int INIT_Y        = 4,
    parameter int REPEAT_CICLOS = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             leftArrow,
    input  logic                             rightArrow,
    input  logic                             upArrow,
    input  logic                             downArrow,
    input  logic                             girar,
    input  logic                             confirmar,
    input  logic                             aceito,
    input  logic                             rejeitado,
    input  logic                             liberar,
    output logic [MAX_CELULAS*2*COORD_W-1:0] posicoesEmbarcacao,
    output logic                             vertical,
    output logic                             valido,
    output logic                             travado
);

    localparam int VEC_W   = MAX_CELULAS * 2 * COORD_W;
    localparam int CNT_W   = $clog2(REPEAT_CICLOS);
    localparam int NUM_BTN = 7;

    localparam int BTN_ESQ   = 0;
    localparam int BTN_DIR   = 1;
    localparam int BTN_CIMA  = 2;
    localparam int BTN_BAIXO = 3;
    localparam int BTN_GIRAR = 4;
    localparam int BTN_CONF  = 5;
    localparam int BTN_LIB   = 6;

    localparam logic [COORD_W-1:0] X0      = COORD_W'(INIT_X);
    localparam logic [COORD_W-1:0] Y0      = COORD_W'(INIT_Y);
    localparam logic [COORD_W-1:0] LIM_X_H = COORD_W'(GRID_W - TAMANHO);
    localparam logic [COORD_W-1:0] LIM_X_V = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] LIM_Y_H = COORD_W'(GRID_H - 1);
    localparam logic [COORD_W-1:0] LIM_Y_V = COORD_W'(GRID_H - TAMANHO);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(REPEAT_CICLOS - 1);

    typedef enum logic [1:0] {
        POSICIONANDO = 2'd0,
        AGUARDANDO   = 2'd1,
        TRAVADO      = 2'd2
    } estado_t;

    // Unused slots carry all-ones so the drawing modules can skip them.
    function automatic logic [VEC_W-1:0] gera_celulas(
        input logic [COORD_W-1:0] ax,
        input logic [COORD_W-1:0] ay,
        input logic               vert
    );
        logic [VEC_W-1:0] vec;
        vec = '1;
        for (int k = 0; k < TAMANHO; k++) begin
            vec[2*k*COORD_W +: COORD_W]     = vert ? ax : ax + COORD_W'(k);
            vec[(2*k+1)*COORD_W +: COORD_W] = vert ? ay + COORD_W'(k) : ay;
        end
        return vec;
    endfunction

    localparam logic [VEC_W-1:0] CELULAS_RESET = gera_celulas(X0, Y0, 1'b0);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] sync1_q, sync1_d;
    logic [NUM_BTN-1:0] sync2_q, sync2_d;
    logic [NUM_BTN-1:0] prev_q, prev_d;
    logic [NUM_BTN-1:0] borda;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         dir_nivel;
    logic [3:0]         dir_prev;
    logic               um_dir;
    logic               tick;
    logic [3:0]         ev_dir;
    logic               ev_unico;

    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               vert_q, vert_d;
    logic [COORD_W-1:0] lim_x, lim_y;
    estado_t            estado_q, estado_d;
    logic               valido_q, valido_d;
    logic               travado_q, travado_d;
    logic [VEC_W-1:0]   cel_q, cel_d;

    always_comb begin
        btn_raw = {liberar, confirmar, girar, downArrow, upArrow, rightArrow, leftArrow};
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        borda   = sync2_q & ~prev_q;
    end

    // Auto-repeat: counts only while the same single direction stays held.
    always_comb begin
        dir_nivel = sync2_q[3:0];
        dir_prev  = prev_q[3:0];
        um_dir    = (dir_nivel != 4'b0) && ((dir_nivel & (dir_nivel - 4'd1)) == 4'b0);
        cnt_d     = '0;
        tick      = 1'b0;
        if (um_dir && (dir_nivel == dir_prev)) begin
            if (cnt_q == CNT_MAX) begin
                tick = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        ev_dir   = borda[3:0] | (tick ? dir_nivel : 4'b0);
        ev_unico = (ev_dir != 4'b0) && ((ev_dir & (ev_dir - 4'd1)) == 4'b0);
    end

    always_comb begin
        lim_x     = vert_q ? LIM_X_V : LIM_X_H;
        lim_y     = vert_q ? LIM_Y_V : LIM_Y_H;
        x_d       = x_q;
        y_d       = y_q;
        vert_d    = vert_q;
        estado_d  = estado_q;
        valido_d  = valido_q;
        travado_d = travado_q;
        case (estado_q)
            POSICIONANDO: begin
                // Rotation takes priority over any move in the same cycle.
                if (borda[BTN_GIRAR]) begin
                    if (vert_q ? (x_q <= LIM_X_H) : (y_q <= LIM_Y_V)) begin
                        vert_d = ~vert_q;
                    end
                end else if (ev_unico) begin
                    if (ev_dir[BTN_ESQ] && (x_q != '0)) begin
                        x_d = x_q - COORD_W'(1);
                    end
                    if (ev_dir[BTN_DIR] && (x_q < lim_x)) begin
                        x_d = x_q + COORD_W'(1);
                    end
                    if (ev_dir[BTN_CIMA] && (y_q < lim_y)) begin
                        y_d = y_q + COORD_W'(1);
                    end
                    if (ev_dir[BTN_BAIXO] && (y_q != '0)) begin
                        y_d = y_q - COORD_W'(1);
                    end
                end
                if (borda[BTN_CONF]) begin
                    estado_d = AGUARDANDO;
                    valido_d = 1'b1;
                end
            end
            AGUARDANDO: begin
                if (rejeitado) begin
                    estado_d = POSICIONANDO;
                    valido_d = 1'b0;
                end else if (aceito) begin
                    estado_d  = TRAVADO;
                    valido_d  = 1'b0;
                    travado_d = 1'b1;
                end
            end
            TRAVADO: begin
                if (borda[BTN_LIB]) begin
                    estado_d  = POSICIONANDO;
                    travado_d = 1'b0;
                end
            end
            default: begin
                estado_d  = POSICIONANDO;
                valido_d  = 1'b0;
                travado_d = 1'b0;
            end
        endcase
        cel_d = gera_celulas(x_d, y_d, vert_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            cnt_q     <= '0;
            x_q       <= X0;
            y_q       <= Y0;
            vert_q    <= 1'b0;
            estado_q  <= POSICIONANDO;
            valido_q  <= 1'b0;
            travado_q <= 1'b0;
            cel_q     <= CELULAS_RESET;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            vert_q    <= vert_d;
            estado_q  <= estado_d;
            valido_q  <= valido_d;
            travado_q <= travado_d;
            cel_q     <= cel_d;
        end
    end

    assign posicoesEmbarcacao = cel_q;
    assign vertical           = vert_q;
    assign valido             = valido_q;
    assign travado            = travado_q;

endmodule

// File: tb/tb_vga_posicionador_embarcacao.sv
// Bench for vga_posicionador_embarcacao: directed table, latency/auto-repeat/reset
// sequences and a randomized run checked against an action-level model.
module tb_vga_posicionador_embarcacao;

    localparam int TAM  = 3;
    localparam int MAXC = 8;
    localparam int CW   = 4;
    localparam int GW   = 10;
    localparam int GH   = 10;
    localparam int VW   = MAXC * 2 * CW;

    localparam logic [6:0] B_L   = 7'h01;
    localparam logic [6:0] B_R   = 7'h02;
    localparam logic [6:0] B_U   = 7'h04;
    localparam logic [6:0] B_D   = 7'h08;
    localparam logic [6:0] B_G   = 7'h10;
    localparam logic [6:0] B_C   = 7'h20;
    localparam logic [6:0] B_LIB = 7'h40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          leftArrow = 1'b0, rightArrow = 1'b0, upArrow = 1'b0, downArrow = 1'b0;
    logic          girar = 1'b0, confirmar = 1'b0, liberar = 1'b0;
    logic          aceito = 1'b0, rejeitado = 1'b0;
    logic [VW-1:0] posicoesEmbarcacao;
    logic          vertical, valido, travado;

    vga_posicionador_embarcacao #(
        .TAMANHO(TAM), .MAX_CELULAS(MAXC), .COORD_W(CW), .GRID_W(GW), .GRID_H(GH),
        .INIT_X(4), .INIT_Y(4), .REPEAT_CICLOS(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .leftArrow(leftArrow), .rightArrow(rightArrow), .upArrow(upArrow),
        .downArrow(downArrow), .girar(girar), .confirmar(confirmar),
        .aceito(aceito), .rejeitado(rejeitado), .liberar(liberar),
        .posicoesEmbarcacao(posicoesEmbarcacao), .vertical(vertical),
        .valido(valido), .travado(travado)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Action-level model: mode 0 placing, 1 waiting for memory, 2 locked.
    int m_x, m_y, m_v, m_mode;

    typedef struct {
        logic [6:0] btn;
        logic       ac;
        logic       rj;
        int         ex;
        int         ey;
        int         ev;
        int         eval;
        int         etrav;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_state(input string nm, input int ex, input int ey, input int ev,
                               input int eval, input int etrav);
        int ax, ay, wx, wy;
        chk({nm, " vertical"}, int'(vertical), ev);
        chk({nm, " valido"}, int'(valido), eval);
        chk({nm, " travado"}, int'(travado), etrav);
        chk({nm, " valido&travado"}, int'(valido & travado), 0);
        for (int k = 0; k < MAXC; k++) begin
            ax = int'(posicoesEmbarcacao[2*k*CW +: CW]);
            ay = int'(posicoesEmbarcacao[(2*k+1)*CW +: CW]);
            if (k < TAM) begin
                wx = (ev != 0) ? ex : ex + k;
                wy = (ev != 0) ? ey + k : ey;
            end else begin
                wx = 15;
                wy = 15;
            end
            chk($sformatf("%s cell%0d.x", nm, k), ax, wx);
            chk($sformatf("%s cell%0d.y", nm, k), ay, wy);
        end
    endtask

    task automatic drive(input logic [6:0] b, input logic ac, input logic rj);
        leftArrow  = b[0];
        rightArrow = b[1];
        upArrow    = b[2];
        downArrow  = b[3];
        girar      = b[4];
        confirmar  = b[5];
        liberar    = b[6];
        aceito     = ac;
        rejeitado  = rj;
    endtask

    // One-cycle pulse, then enough idle cycles for the synchronizer path to settle.
    task automatic apply_action(input logic [6:0] b, input logic ac, input logic rj);
        drive(b, ac, rj);
        @(negedge clk);
        drive(7'h0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        drive(7'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m_x = 4; m_y = 4; m_v = 0; m_mode = 0;
    endtask

    task automatic model_action(input logic [6:0] b, input logic ac, input logic rj);
        int ndir;
        ndir = $countones(b[3:0]);
        case (m_mode)
            0: begin
                if (b[4]) begin
                    if (m_v == 0 && m_y <= GH - TAM) m_v = 1;
                    else if (m_v == 1 && m_x <= GW - TAM) m_v = 0;
                end else if (ndir == 1) begin
                    if (b[0] && m_x > 0) m_x--;
                    if (b[1] && m_x < ((m_v != 0) ? GW - 1 : GW - TAM)) m_x++;
                    if (b[2] && m_y < ((m_v != 0) ? GH - TAM : GH - 1)) m_y++;
                    if (b[3] && m_y > 0) m_y--;
                end
                if (b[5]) m_mode = 1;
            end
            1: begin
                if (rj) m_mode = 0;
                else if (ac) m_mode = 2;
            end
            default: begin
                if (b[6]) m_mode = 0;
            end
        endcase
    endtask

    task automatic add(input logic [6:0] b, input logic ac, input logic rj, input int ex,
                       input int ey, input int ev, input int eval, input int etrav);
        vec_t r;
        r.btn = b; r.ac = ac; r.rj = rj;
        r.ex = ex; r.ey = ey; r.ev = ev; r.eval = eval; r.etrav = etrav;
        tbl.push_back(r);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] b;
        logic       ac, rj;
        int         kind, d1, d2, steps, wy;

        // Directed table from reset: clamping, rotation legality, handshake paths.
        add(B_R, 0, 0, 5, 4, 0, 0, 0);
        add(B_R, 0, 0, 6, 4, 0, 0, 0);
        add(B_R, 0, 0, 7, 4, 0, 0, 0);
        add(B_R, 0, 0, 7, 4, 0, 0, 0);
        add(B_L, 0, 0, 6, 4, 0, 0, 0);
        add(B_L, 0, 0, 5, 4, 0, 0, 0);
        add(B_L, 0, 0, 4, 4, 0, 0, 0);
        add(B_L, 0, 0, 3, 4, 0, 0, 0);
        add(B_L, 0, 0, 2, 4, 0, 0, 0);
        add(B_U, 0, 0, 2, 5, 0, 0, 0);
        add(B_U, 0, 0, 2, 6, 0, 0, 0);
        add(B_U, 0, 0, 2, 7, 0, 0, 0);
        add(B_U, 0, 0, 2, 8, 0, 0, 0);
        add(B_G, 0, 0, 2, 8, 0, 0, 0);
        add(B_D, 0, 0, 2, 7, 0, 0, 0);
        add(B_G, 0, 0, 2, 7, 1, 0, 0);
        add(B_U, 0, 0, 2, 7, 1, 0, 0);
        add(B_R, 0, 0, 3, 7, 1, 0, 0);
        add(B_C, 0, 0, 3, 7, 1, 1, 0);
        add(B_R, 0, 0, 3, 7, 1, 1, 0);
        add(B_G, 0, 0, 3, 7, 1, 1, 0);
        add(7'h0, 0, 1, 3, 7, 1, 0, 0);
        add(B_C, 0, 0, 3, 7, 1, 1, 0);
        add(7'h0, 1, 1, 3, 7, 1, 0, 0);
        add(B_C, 0, 0, 3, 7, 1, 1, 0);
        add(7'h0, 1, 0, 3, 7, 1, 0, 1);
        add(B_L, 0, 0, 3, 7, 1, 0, 1);
        add(B_C, 0, 0, 3, 7, 1, 0, 1);
        add(7'h0, 0, 1, 3, 7, 1, 0, 1);
        add(B_LIB, 0, 0, 3, 7, 1, 0, 0);
        add(B_L, 0, 0, 2, 7, 1, 0, 0);
        add(B_L | B_R, 0, 0, 2, 7, 1, 0, 0);
        add(B_G | B_U, 0, 0, 2, 7, 0, 0, 0);
        add(7'h0, 1, 0, 2, 7, 0, 0, 0);

        do_reset();
        check_state("reset", 4, 4, 0, 0, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            apply_action(tbl[i].btn, tbl[i].ac, tbl[i].rj);
            check_state($sformatf("row%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].ev,
                        tbl[i].eval, tbl[i].etrav);
        end

        // Latency: a pulse sampled at edge N moves the anchor at edge N+2, not before.
        do_reset();
        drive(B_R, 1'b0, 1'b0);
        @(negedge clk);
        drive(7'h0, 1'b0, 1'b0);
        chk("latency edge N", int'(posicoesEmbarcacao[CW-1:0]), 4);
        @(negedge clk);
        chk("latency edge N+1", int'(posicoesEmbarcacao[CW-1:0]), 4);
        @(negedge clk);
        chk("latency edge N+2", int'(posicoesEmbarcacao[CW-1:0]), 5);

        // Held downArrow: one step on the edge, then one per 8 cycles, clamped at 0.
        do_reset();
        drive(B_D, 1'b0, 1'b0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            steps = (c < 2) ? 0 : 1 + (c - 2) / 8;
            wy = (4 - steps < 0) ? 0 : 4 - steps;
            chk($sformatf("hold c%0d y", c), int'(posicoesEmbarcacao[2*CW-1:CW]), wy);
        end
        drive(7'h0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_state("hold release", 4, 0, 0, 0, 0);

        // Reset while waiting for memory drops valido without a clock edge.
        do_reset();
        apply_action(B_R, 1'b0, 1'b0);
        apply_action(B_C, 1'b0, 1'b0);
        check_state("pre-reset wait", 5, 4, 0, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_state("async reset", 4, 4, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized actions against the model.
        do_reset();
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 11);
            b = 7'h0; ac = 1'b0; rj = 1'b0;
            d1 = $urandom_range(0, 3);
            d2 = (d1 + $urandom_range(1, 3)) % 4;
            case (kind)
                0, 1, 2, 3: b[kind] = 1'b1;
                4:  begin b[d1] = 1'b1; b[d2] = 1'b1; end
                5:  b = B_G;
                6:  begin b = B_G; b[d1] = 1'b1; end
                7:  b = B_C;
                8:  ac = 1'b1;
                9:  rj = 1'b1;
                10: begin ac = 1'b1; rj = 1'b1; end
                default: b = B_LIB;
            endcase
            apply_action(b, ac, rj);
            model_action(b, ac, rj);
            check_state($sformatf("rand%0d", i), m_x, m_y, m_v,
                        (m_mode == 1) ? 1 : 0, (m_mode == 2) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
